// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
// Imported by the ID/EX control decoder and by ex_muldiv_unit.
//   MDU_NBITS   : default operand/result width
//   OP_*        : 3-bit MDU opcodes carried in ID/EX
//   mdu_state_e : MDU sequencer state encoding
package mdu_pkg;

    localparam int MDU_NBITS = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divide core, unsigned, one quotient bit
// per i_step. Sign handling and divide-by-zero policy live in the caller.
// Ports:
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_load                 : capture dividend/divisor, clear partial remainder
//   i_step                 : perform one restoring-subtract iteration
//   i_dividend, i_divisor  : unsigned operands
//   o_quot, o_rem          : quotient / remainder after NBITS steps
module mdu_divider #(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_step,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_dividend,
    input  logic [NBITS-1:0] i_divisor,
    output logic [NBITS-1:0] o_quot,
    output logic [NBITS-1:0] o_rem
);

    logic [NBITS-1:0] quo_q, rem_q, dvs_q;
    logic [NBITS:0]   shifted;
    logic             ge;
    logic [NBITS-1:0] rem_d;

    // Dividend bits shift out of the top of quo_q while quotient bits shift in
    // at the bottom. rem_q < divisor holds between steps, so the post-subtract
    // remainder always fits in NBITS bits.
    always_comb begin
        shifted = {rem_q, quo_q[NBITS-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_d   = ge ? (shifted[NBITS-1:0] - dvs_q) : shifted[NBITS-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (i_load) begin
            quo_q <= i_dividend;
            rem_q <= '0;
            dvs_q <= i_divisor;
        end else if (i_step) begin
            quo_q <= {quo_q[NBITS-2:0], ge};
            rem_q <= rem_d;
        end
    end

    assign o_quot = quo_q;
    assign o_rem  = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage iterative multiply/divide unit with HI/LO.
// MULT/MULTU/DIV/DIVU take NBITS RUN cycles plus one FIX cycle; results land
// in HI/LO with a one-cycle o_done pulse. MTHI/MTLO write at the accepting
// edge, MFHI/MFLO read combinationally.
// Build option: define MDU_DIV_EN to implement DIV/DIVU; without it the
// divider is absent and DIV/DIVU are ignored.
// Ports:
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start, i_op       : MDU instruction valid in EX and its opcode
//   i_src_a, i_src_b    : operands from ID/EX
//   i_flush             : abort in-flight op / drop the current one
//   o_stall             : hold the new MDU instruction in EX
//   o_busy, o_done      : RUN/FIX indicator, result-visible pulse
//   o_result            : MFHI/MFLO read data
//   o_hi, o_lo          : architectural HI/LO
module ex_muldiv_unit
    import mdu_pkg::*;
#(
    parameter int NBITS = MDU_NBITS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [NBITS-1:0] i_src_a,
    input  logic [NBITS-1:0] i_src_b,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [NBITS-1:0] o_result,
    output logic [NBITS-1:0] o_hi,
    output logic [NBITS-1:0] o_lo
);

    localparam int CW = $clog2(NBITS);

    mdu_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic               mul_q, neg_q, done_q;
    logic [NBITS-1:0]   hi_q, lo_q, mcand_q;
    logic [2*NBITS-1:0] prod_q;

    logic               is_mul, is_div, is_signed, sa, sb, accept;
    logic [NBITS-1:0]   abs_a, abs_b;
    logic [NBITS:0]     mul_sum;
    logic [2*NBITS-1:0] prod_fix;
    logic [NBITS-1:0]   res_hi_d, res_lo_d;

    always_comb begin
        is_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef MDU_DIV_EN
        is_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
`else
        is_div    = 1'b0;
`endif
        is_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
        sa        = is_signed & i_src_a[NBITS-1];
        sb        = is_signed & i_src_b[NBITS-1];
        abs_a     = sa ? -i_src_a : i_src_a;
        abs_b     = sb ? -i_src_b : i_src_b;
        accept    = (state_q == ST_IDLE) && i_start && !i_flush;
        // Shift-add: multiplier sits in prod_q's low half and is consumed LSB first.
        mul_sum   = {1'b0, prod_q[2*NBITS-1:NBITS]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
        prod_fix  = neg_q ? -prod_q : prod_q;
    end

`ifdef MDU_DIV_EN
    logic             rem_neg_q, divz_q;
    logic [NBITS-1:0] div_quot, div_rem, quot_fix, rem_fix;

    mdu_divider #(.NBITS(NBITS)) u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_step     ((state_q == ST_RUN) && !mul_q && !i_flush),
        .i_load     (accept && is_div),
        .i_dividend (abs_a),
        .i_divisor  (abs_b),
        .o_quot     (div_quot),
        .o_rem      (div_rem)
    );

    assign quot_fix = neg_q ? -div_quot : div_quot;
    // With a zero divisor the core returns |A| as remainder; re-applying A's
    // sign reproduces the raw dividend for HI.
    assign rem_fix  = rem_neg_q ? -div_rem : div_rem;
`endif

    always_comb begin
        res_hi_d = prod_fix[2*NBITS-1:NBITS];
        res_lo_d = prod_fix[NBITS-1:0];
`ifdef MDU_DIV_EN
        if (!mul_q) begin
            res_hi_d = rem_fix;
            res_lo_d = divz_q ? '1 : quot_fix;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mul_q     <= 1'b0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
`ifdef MDU_DIV_EN
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                            mul_q   <= is_mul;
                            neg_q   <= sa ^ sb;
                            mcand_q <= abs_a;
                            prod_q  <= {{NBITS{1'b0}}, abs_b};
`ifdef MDU_DIV_EN
                            rem_neg_q <= sa;
                            divz_q    <= (i_src_b == '0);
`endif
                        end else if (i_op == OP_MTHI) begin
                            hi_q <= i_src_a;
                        end else if (i_op == OP_MTLO) begin
                            lo_q <= i_src_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (mul_q)
                            prod_q <= {mul_sum, prod_q[NBITS-1:1]};
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(NBITS - 1))
                            state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!i_flush) begin
                        hi_q   <= res_hi_d;
                        lo_q   <= res_lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_result = '0;
        if (i_op == OP_MFHI)      o_result = hi_q;
        else if (i_op == OP_MFLO) o_result = lo_q;
    end

    assign o_stall = i_start && (state_q != ST_IDLE);
    assign o_busy  = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign o_done  = done_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit.
// Division cases are exercised when MDU_DIV_EN is defined; otherwise DIV is
// checked to be ignored.
module tb_ex_muldiv_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, busy, done;
    logic [31:0] result, hi, lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.NBITS(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_src_a(src_a), .i_src_b(src_b), .i_flush(flush),
        .o_stall(stall), .o_busy(busy), .o_done(done),
        .o_result(result), .o_hi(hi), .o_lo(lo)
    );

    // Drive a one-cycle MT-style instruction.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk); start = 1'b0;
    endtask

    // Issue a long op, then sample each negedge from acceptance+1 until o_done.
    // lat is cycles from the accepting edge to the o_done cycle (>=100 = timeout).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n);
        issue(o, a, b);
        lat = 1; busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk); lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk); start = 1'b1; op = OP_MFHI; #1;
        total++; if (hi !== 32'h0)  begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0)  begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_idle_stall got=%b exp=0", stall); end
        start = 1'b0;
    endtask

    task automatic test_mult();
        int lat, bn;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat, bn);
        total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        total++; if (bn !== 33)  begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=33", bn); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, lat, bn);
        total++; if (hi !== 32'h0000_0002) begin bad++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bn);
        total++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            bad++; $display("FAIL mult_minmin got=%h_%h exp=40000000_00000000", hi, lo); end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int lat, bn;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bn);
        total++; if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_q got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_r got=%h exp=ffffffff", hi); end
        run_op(OP_DIVU, 32'd7, 32'd0, lat, bn);
        total++; if (lat !== 34) begin bad++; $display("FAIL divu0_latency got=%0d exp=34", lat); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
        total++; if (hi !== 32'd7) begin bad++; $display("FAIL divu0_hi got=%h exp=00000007", hi); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, bn);
        total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin
            bad++; $display("FAIL div0_signed got=%h/%h exp=fffffff9/ffffffff", hi, lo); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bn);
        total++; if (lo !== 32'd14 || hi !== 32'd2) begin
            bad++; $display("FAIL divu_basic got=%h/%h exp=00000002/0000000e", hi, lo); end
    endtask
`else
    task automatic test_div_disabled();
        bit saw_done = 1'b0;
        issue(OP_MTHI, 32'h11, 32'h0);
        issue(OP_MTLO, 32'h22, 32'h0);
        issue(OP_DIV, 32'd7, 32'd2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL divoff_busy got=%b exp=0", busy); end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) saw_done = 1'b1; end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL divoff_done got=%b exp=0", saw_done); end
        total++; if (hi !== 32'h11 || lo !== 32'h22) begin
            bad++; $display("FAIL divoff_hilo got=%h/%h exp=00000011/00000022", hi, lo); end
    endtask
`endif

    task automatic test_move();
        issue(OP_MTHI, 32'h1234, 32'h0);
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi got=%h exp=00001234", hi); end
        issue(OP_MTLO, 32'h5678, 32'h0);
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mtlo got=%h exp=00005678", lo); end
        op = OP_MFHI; #1;
        total++; if (result !== 32'h1234) begin bad++; $display("FAIL mfhi got=%h exp=00001234", result); end
        op = OP_MFLO; #1;
        total++; if (result !== 32'h5678) begin bad++; $display("FAIL mflo got=%h exp=00005678", result); end
        op = OP_MULT; #1;
        total++; if (result !== 32'h0) begin bad++; $display("FAIL result_nonmf got=%h exp=0", result); end
        // flush beats a same-cycle start in IDLE
        @(negedge clk); start = 1'b1; op = OP_MTLO; src_a = 32'h99; flush = 1'b1;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL flush_mt got=%h exp=00005678", lo); end
    endtask

    task automatic test_flush();
        bit saw_done = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        issue(OP_MTHI, 32'h1234, 32'h0);
        issue(OP_MULT, 32'd5, 32'd6);          // now in cycle t0+1
        @(negedge clk); @(negedge clk);        // cycle t0+3
        start = 1'b1; op = OP_MFLO; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b exp=1", stall); end
        for (int i = 3; i < 10; i++) @(negedge clk);
        start = 1'b0; flush = 1'b1;            // cycle t0+10
        @(negedge clk); flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", busy); end
        total++; if (hi !== 32'h1234 || lo !== 32'h0) begin
            bad++; $display("FAIL flush_hilo got=%h/%h exp=00001234/00000000", hi, lo); end
        for (int i = 0; i < 40; i++) begin if (done) saw_done = 1'b1; @(negedge clk); end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", saw_done); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_op(OP_MULTU, 32'd7, 32'd8, lat, bn);
        total++; if (lo !== 32'd56) begin bad++; $display("FAIL b2b_first got=%h exp=00000038", lo); end
        start = 1'b1; op = OP_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd3; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall); end
        @(negedge clk); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        lat = 1;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF7) begin
            bad++; $display("FAIL b2b_second got=%h_%h exp=ffffffff_fffffff7", hi, lo); end
    endtask

    task automatic test_reset_mid_run();
        issue(OP_MTHI, 32'hAAAA, 32'h0);
        issue(OP_MULT, 32'd5, 32'd6);
        for (int i = 0; i < 5; i++) @(negedge clk);
        start = 1'b1; op = OP_MFHI; rst_n = 1'b0; #1;
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("FAIL rstrun_hilo got=%h/%h exp=0/0", hi, lo); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rstrun_ctrl got=busy%b done%b stall%b exp=000", busy, done, stall); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rstrun_result got=%h exp=0", result); end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = OP_MFHI; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_mult();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_move();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
